// File: rtl/ah_dec_pkg.sv
// ---------------------------------------------------------------------------
// ah_dec_pkg
// Shared types and helpers for the AH packet-path range decoder.
//   AH_ADDR_W   : default width of the decoded field and of the range bounds
//   ah_range_t  : one range-table entry {base, limit, en}
//   ah_lsb_idx  : index of the lowest set bit of a vector of up to 64 bits
// ---------------------------------------------------------------------------
package ah_dec_pkg;

    localparam int AH_ADDR_W = 34;

    typedef struct packed {
        logic [AH_ADDR_W-1:0] base;
        logic [AH_ADDR_W-1:0] limit;
        logic                 en;
    } ah_range_t;

    // Scanning downward means the last assignment is the lowest set bit.
    // An all-zero vector returns 0.
    function automatic logic [5:0] ah_lsb_idx(input logic [63:0] vec);
        logic [5:0] idx;
        idx = '0;
        for (int i = 63; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 6'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ah_range_cmp.sv
// ---------------------------------------------------------------------------
// ah_range_cmp
// Single decode window: hit when the entry is enabled and
// base <= field <= limit (unsigned, full width). An entry whose base is
// above its limit can never hit.
//   field : value being decoded
//   range : table entry {base, limit, en}
//   hit   : window match
// ---------------------------------------------------------------------------
module ah_range_cmp
    import ah_dec_pkg::*;
(
    input  logic [AH_ADDR_W-1:0] field,
    input  ah_range_t            range,
    output logic                 hit
);

    assign hit = range.en && (range.base <= field) && (field <= range.limit);

endmodule

// File: rtl/ah_range_decoder_pipe.sv
// ---------------------------------------------------------------------------
// ah_range_decoder_pipe
// Programmable address-range decoder with a one-entry registered output.
// The ingress field is matched against N_CLIENTS [base, limit] windows; the
// lowest-index hit wins. Result is presented one cycle after acceptance
// under valid/ready flow control, and delivered no-match results are counted.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   cfg_we/idx/base/limit/en    range-table write port
//   in_valid, in_ready          ingress handshake
//   ingress_pkt_field           field to decode
//   out_valid, out_ready        result handshake
//   decoded_onehot              winner bit only
//   decoded_binary              winner index
//   dec_err                     no enabled window matched
//   multi_hit                   more than one window matched
//   err_cnt, err_cnt_clr        saturating count of delivered dec_err results
// ---------------------------------------------------------------------------
module ah_range_decoder_pipe
    import ah_dec_pkg::*;
#(
    parameter int ADDR_W    = AH_ADDR_W,
    parameter int N_CLIENTS = 8,
    parameter int IDX_W     = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 cfg_we,
    input  logic [IDX_W-1:0]     cfg_idx,
    input  logic [ADDR_W-1:0]    cfg_base,
    input  logic [ADDR_W-1:0]    cfg_limit,
    input  logic                 cfg_en,

    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ADDR_W-1:0]    ingress_pkt_field,

    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N_CLIENTS-1:0] decoded_onehot,
    output logic [IDX_W-1:0]     decoded_binary,
    output logic                 dec_err,
    output logic                 multi_hit,

    output logic [CNT_W-1:0]     err_cnt,
    input  logic                 err_cnt_clr
);

    // The table entry type is sized by the package width.
    if (ADDR_W != AH_ADDR_W) begin : g_width_check
        $error("ah_range_decoder_pipe: ADDR_W must equal ah_dec_pkg::AH_ADDR_W");
    end

    ah_range_t            tbl [N_CLIENTS];
    logic [N_CLIENTS-1:0] hit;
    logic [N_CLIENTS-1:0] win_onehot;
    logic [IDX_W-1:0]     win_idx;
    logic                 any_hit;
    logic                 many_hit;
    logic                 accept;
    logic                 deliver;

    // Range table. Lookups read the registered table, so a write lands
    // after any lookup accepted on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CLIENTS; i++) begin
                tbl[i] <= '0;
            end
        end else if (cfg_we && (int'(cfg_idx) < N_CLIENTS)) begin
            tbl[cfg_idx] <= '{base: cfg_base, limit: cfg_limit, en: cfg_en};
        end
    end

    for (genvar g = 0; g < N_CLIENTS; g++) begin : g_cmp
        ah_range_cmp u_cmp (
            .field (ingress_pkt_field),
            .range (tbl[g]),
            .hit   (hit[g])
        );
    end

    // Lowest set bit isolation and "more than one bit" test.
    assign win_onehot = hit & ~(hit - N_CLIENTS'(1));
    assign any_hit    = |hit;
    assign many_hit   = |(hit & (hit - N_CLIENTS'(1)));
    assign win_idx    = IDX_W'(ah_lsb_idx(64'(hit)));

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign deliver  = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            decoded_onehot <= '0;
            decoded_binary <= '0;
            dec_err        <= 1'b0;
            multi_hit      <= 1'b0;
        end else begin
            if (accept) begin
                out_valid      <= 1'b1;
                decoded_onehot <= win_onehot;
                decoded_binary <= win_idx;
                dec_err        <= !any_hit;
                multi_hit      <= many_hit;
            end else if (out_ready) begin
                // Drain with nothing new: data outputs keep their last value.
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_cnt_clr) begin
            err_cnt <= '0;
        end else if (deliver && dec_err && (err_cnt != {CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ah_range_decoder_pipe.sv
module tb_ah_range_decoder_pipe;

    localparam int AW = 34;
    localparam int N  = 8;
    localparam int IW = 3;
    localparam int CW = 16;

    logic          clk;
    logic          rst_n;
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [AW-1:0] cfg_base;
    logic [AW-1:0] cfg_limit;
    logic          cfg_en;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] ingress_pkt_field;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  decoded_onehot;
    logic [IW-1:0] decoded_binary;
    logic          dec_err;
    logic          multi_hit;
    logic [CW-1:0] err_cnt;
    logic          err_cnt_clr;

    ah_range_decoder_pipe #(
        .ADDR_W    (AW),
        .N_CLIENTS (N),
        .IDX_W     (IW),
        .CNT_W     (CW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cfg_we            (cfg_we),
        .cfg_idx           (cfg_idx),
        .cfg_base          (cfg_base),
        .cfg_limit         (cfg_limit),
        .cfg_en            (cfg_en),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .ingress_pkt_field (ingress_pkt_field),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .decoded_onehot    (decoded_onehot),
        .decoded_binary    (decoded_binary),
        .dec_err           (dec_err),
        .multi_hit         (multi_hit),
        .err_cnt           (err_cnt),
        .err_cnt_clr       (err_cnt_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [N-1:0]  oh;
        logic [IW-1:0] bin;
        logic          err;
        logic          multi;
    } res_t;

    res_t          sbq[$];
    logic [AW-1:0] m_base  [N];
    logic [AW-1:0] m_limit [N];
    bit            m_en    [N];
    bit            m_full;
    int unsigned   exp_err;

    function automatic res_t ref_decode(input logic [AW-1:0] f);
        res_t r;
        int   hits = 0;
        int   win  = -1;
        for (int i = 0; i < N; i++) begin
            if (m_en[i] && m_base[i] <= f && f <= m_limit[i]) begin
                hits++;
                if (win < 0) win = i;
            end
        end
        r.oh    = (win >= 0) ? N'(1 << win) : '0;
        r.bin   = (win >= 0) ? IW'(win) : '0;
        r.err   = (hits == 0);
        r.multi = (hits > 1);
        return r;
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < N; i++) begin
            m_base[i]  = '0;
            m_limit[i] = '0;
            m_en[i]    = 1'b0;
        end
        sbq.delete();
        m_full  = 1'b0;
        exp_err = 0;
    endtask

    // Stimulus side: on each edge decide acceptance and push the expected result,
    // then apply any table write (so it never affects the same-edge lookup).
    always @(posedge clk) begin
        bit acc;
        if (rst_n) begin
            acc = in_valid && (!m_full || out_ready);
            if (acc) sbq.push_back(ref_decode(ingress_pkt_field));
            m_full = acc || (m_full && !out_ready);
            if (cfg_we && int'(cfg_idx) < N) begin
                m_base[cfg_idx]  = cfg_base;
                m_limit[cfg_idx] = cfg_limit;
                m_en[cfg_idx]    = cfg_en;
            end
        end
    end

    // Monitor: compares whatever the DUT presents against the queue head.
    always @(negedge clk) begin
        res_t e;
        bit   have;
        if (rst_n) begin
            chk("out_valid", 64'(out_valid), 64'(m_full));
            chk("in_ready", 64'(in_ready), 64'(!m_full || out_ready));
            chk("err_cnt", 64'(err_cnt), 64'(exp_err));
            have = 1'b0;
            if (m_full) begin
                if (sbq.size() == 0) begin
                    chk("sb_nonempty", 64'(sbq.size()), 64'(1));
                end else begin
                    e    = sbq[0];
                    have = 1'b1;
                    chk("decoded_onehot", 64'(decoded_onehot), 64'(e.oh));
                    chk("decoded_binary", 64'(decoded_binary), 64'(e.bin));
                    chk("dec_err", 64'(dec_err), 64'(e.err));
                    chk("multi_hit", 64'(multi_hit), 64'(e.multi));
                    if (out_ready) void'(sbq.pop_front());
                end
            end
            if (err_cnt_clr) exp_err = 0;
            else if (have && out_ready && e.err && exp_err < (2**CW - 1)) exp_err++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [AW-1:0] f);
        in_valid          = 1'b1;
        ingress_pkt_field = f;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic cfg(input int idx, input logic [AW-1:0] b, input logic [AW-1:0] l, input bit en);
        cfg_we    = 1'b1;
        cfg_idx   = IW'(idx);
        cfg_base  = b;
        cfg_limit = l;
        cfg_en    = en;
        tick();
        cfg_we = 1'b0;
    endtask

    logic [AW-1:0] amax;
    logic [AW-1:0] rb;

    initial begin
        amax              = '1;
        rst_n             = 1'b0;
        cfg_we            = 1'b0;
        cfg_idx           = '0;
        cfg_base          = '0;
        cfg_limit         = '0;
        cfg_en            = 1'b0;
        in_valid          = 1'b0;
        ingress_pkt_field = '0;
        out_ready         = 1'b1;
        err_cnt_clr       = 1'b0;
        mdl_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_onehot", 64'(decoded_onehot), 64'(0));
        chk("rst_binary", 64'(decoded_binary), 64'(0));
        chk("rst_dec_err", 64'(dec_err), 64'(0));
        chk("rst_multi_hit", 64'(multi_hit), 64'(0));
        chk("rst_err_cnt", 64'(err_cnt), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        rst_n = 1'b1;
        tick();

        // Empty table: three errors, then clear on the fourth delivery.
        send(34'h1234);
        send(34'h0);
        send(amax);
        tick();
        chk("err_cnt_three", 64'(err_cnt), 64'(3));
        send(34'h5);
        err_cnt_clr = 1'b1;
        tick();
        err_cnt_clr = 1'b0;
        tick();
        chk("err_cnt_clr_wins", 64'(err_cnt), 64'(0));

        // Basic and overlapping windows.
        cfg(0, 34'h0000, 34'h0FFF, 1'b1);
        cfg(1, 34'h1000, 34'h1FFF, 1'b1);
        send(34'h1800);
        tick();
        cfg(2, 34'h0800, 34'h17FF, 1'b1);
        send(34'h1000);
        tick();

        // Backpressure for four cycles, then back-to-back drain.
        out_ready         = 1'b0;
        in_valid          = 1'b1;
        ingress_pkt_field = 34'h0100;
        tick();
        for (int i = 0; i < 4; i++) begin
            ingress_pkt_field = 34'($urandom_range(0, 16'h3FFF));
            chk("stall_in_ready", 64'(in_ready), 64'(0));
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ingress_pkt_field = 34'($urandom_range(0, 16'h3FFF));
            tick();
        end
        in_valid = 1'b0;
        repeat (2) tick();

        // Table write on the same edge as a lookup.
        cfg_we            = 1'b1;
        cfg_idx           = 3'd3;
        cfg_base          = 34'h2000;
        cfg_limit         = 34'h2FFF;
        cfg_en            = 1'b1;
        in_valid          = 1'b1;
        ingress_pkt_field = 34'h2000;
        tick();
        cfg_we = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();

        // Boundaries: single-value window at the top, inverted window.
        cfg(4, amax, amax, 1'b1);
        cfg(5, 34'h10, 34'h0F, 1'b1);
        send(amax);
        send(amax - 34'd1);
        send(34'h10);
        send(34'h0F);
        tick();

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            cfg_we = ($urandom_range(0, 7) == 0);
            if (cfg_we) begin
                cfg_idx = IW'($urandom_range(0, N - 1));
                rb      = 34'($urandom_range(0, 16'h3000));
                if ($urandom_range(0, 7) == 0) rb = amax - 34'($urandom_range(0, 8));
                cfg_base  = rb;
                cfg_limit = ($urandom_range(0, 5) == 0) ? rb - 34'd1 : rb + 34'($urandom_range(0, 16'h0800));
                if (cfg_limit < rb && cfg_base > amax - 34'd9) cfg_limit = amax;
                cfg_en = ($urandom_range(0, 3) != 0);
            end
            in_valid          = ($urandom_range(0, 3) != 0);
            ingress_pkt_field = ($urandom_range(0, 7) == 0) ? amax - 34'($urandom_range(0, 8))
                                                            : 34'($urandom_range(0, 16'h3FFF));
            out_ready   = ($urandom_range(0, 3) != 0);
            err_cnt_clr = ($urandom_range(0, 31) == 0);
            tick();
        end
        cfg_we      = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        err_cnt_clr = 1'b0;
        repeat (3) tick();

        // Reset while a result is pending.
        out_ready         = 1'b0;
        in_valid          = 1'b1;
        ingress_pkt_field = 34'h1800;
        tick();
        in_valid = 1'b0;
        chk("pre_rst_out_valid", 64'(out_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'(0));
        chk("async_rst_err_cnt", 64'(err_cnt), 64'(0));
        mdl_reset();
        repeat (2) tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        send(34'h1800);
        repeat (2) tick();
        chk("sb_drained", 64'(sbq.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ah_range_decoder_pipe.md
Name: ah_range_decoder_pipe

Overview:
- Programmable address-range decoder for the AH packet path.
- Compares an ingress packet field against N_CLIENTS runtime-programmable [base, limit] windows.
- Returns a registered one-hot hit vector, the binary index of the winning client, and error flags.
- Sits between the ingress parser and the client egress mux; supersedes the fixed-constant combinational decoder with registered config, valid/ready flow control and error accounting.

Parameters:
- ADDR_W, 34, width of the ingress field and of the range bounds.
- N_CLIENTS, 8, number of decode windows (1..64).
- IDX_W, $clog2(N_CLIENTS) (minimum 1), width of the client index.
- CNT_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  write strobe for one range-table entry.
- cfg_idx  in  IDX_W  entry being written.
- cfg_base  in  ADDR_W  inclusive lower bound.
- cfg_limit  in  ADDR_W  inclusive upper bound.
- cfg_en  in  1  entry enable.
- in_valid  in  1  ingress field valid.
- in_ready  out  1  decoder can accept.
- ingress_pkt_field  in  ADDR_W  field to decode.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- decoded_onehot  out  N_CLIENTS  per-client hit, masked to the winner.
- decoded_binary  out  IDX_W  index of the winning client.
- dec_err  out  1  no enabled window matched.
- multi_hit  out  1  more than one window matched.
- err_cnt  out  CNT_W  count of dec_err results delivered.
- err_cnt_clr  in  1  synchronous clear of err_cnt.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - every table entry has base=0, limit=0, en=0.
  - out_valid=0, decoded_onehot=0, decoded_binary=0, dec_err=0, multi_hit=0, err_cnt=0, in_ready=1.
- Range table:
  - cfg_we=1 writes {base, limit, en} into entry cfg_idx at the clock edge.
  - cfg_idx >= N_CLIENTS: write ignored.
  - Write in cycle N affects lookups accepted in cycle N+1 onward, never the lookup accepted in cycle N.
- Match rule: hit[i] = en[i] && base[i] <= field && field <= limit[i], unsigned, full ADDR_W compare.
  - base > limit: entry never matches.
  - base == limit: matches that single value.
- Priority: the lowest hit index wins.
  - decoded_onehot has only the winner bit set; decoded_binary is its index.
  - multi_hit = popcount(hit) > 1.
  - No hit: decoded_onehot=0, decoded_binary=0, dec_err=1, multi_hit=0.
- Pipeline: one-entry output register, latency 1 cycle.
  - in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready; result is registered and out_valid=1 the next cycle.
  - out_valid=1 && out_ready=0: all outputs held stable; in_ready=0.
  - Simultaneous drain and accept: new result loaded, out_valid stays 1, no bubble.
  - in_valid=0 while draining: out_valid falls to 0; data outputs keep their last value.
- Error counter: increments by 1 when a result with dec_err=1 is delivered (out_valid && out_ready); saturates at 2^CNT_W-1.
  - err_cnt_clr has priority over an increment in the same cycle; result is 0.
- Reset mid-transaction: any pending result is dropped; the table reverts to disabled.

Decomposition:
- Package ah_dec_pkg holds:
  - typedef ah_range_t {base, limit, en}.
  - the ADDR_W default.
  - a function for the lowest-set-bit priority encode.
- Sub-module ah_range_cmp: one window compare (field, ah_range_t) -> hit, instantiated N_CLIENTS times in a generate loop.

Test Plan:
- Program entry0=[0x0000,0x0FFF], entry1=[0x1000,0x1FFF], both enabled; field=0x1800 -> next cycle out_valid=1, decoded_onehot=0x02, decoded_binary=1, dec_err=0.
- Program entry2=[0x0800,0x17FF] overlapping entry1; field=0x1000 -> decoded_binary=1, multi_hit=1.
- All entries disabled after reset; send 3 fields with out_ready=1 -> dec_err=1 each time, err_cnt=3; err_cnt_clr in the same cycle as a 4th error delivery -> err_cnt=0.
- out_ready=0 for 4 cycles with in_valid=1 -> in_ready=0 and outputs stable; release -> back-to-back results, one per cycle, no bubble.
- cfg write in the same cycle a lookup of 0x2000 is accepted, enabling entry3=[0x2000,0x2FFF] -> that lookup gives dec_err=1; the next lookup of 0x2000 gives decoded_binary=3.
- Boundaries: base=limit=0x3_FFFF_FFFF gives a hit at that value only; base=0x10, limit=0x0F never hits; assert rst_n with out_valid=1 -> out_valid=0 immediately.
